// File: rtl/i2s_pkg.sv
// Shared I2S encodings and helpers, common to the transmit and receive paths.
// Also holds the receiver state type and the data-length decoder.
package i2s_pkg;

  localparam logic [1:0] WM_OFF  = 2'b00;
  localparam logic [1:0] WM_SEND = 2'b01;
  localparam logic [1:0] WM_RECV = 2'b10;

  localparam logic [1:0] FMT_I2S = 2'b00;
  localparam logic [1:0] FMT_MSB = 2'b01;
  localparam logic [1:0] FMT_LSB = 2'b10;

  localparam logic [1:0] CHM_STEREO = 2'b00;
  localparam logic [1:0] CHM_LEFT   = 2'b01;
  localparam logic [1:0] CHM_RIGHT  = 2'b10;

  localparam logic CHL_16 = 1'b0;
  localparam logic CHL_32 = 1'b1;

  localparam logic [1:0] DAL_8  = 2'b00;
  localparam logic [1:0] DAL_16 = 2'b01;
  localparam logic [1:0] DAL_24 = 2'b10;
  localparam logic [1:0] DAL_32 = 2'b11;

  typedef enum logic [1:0] {IDLE, SYNC, RECV} rx_state_e;

  function automatic logic [5:0] dal_bits(input logic [1:0] dal);
    logic [5:0] bits;
    case (dal)
      DAL_8:   bits = 6'd8;
      DAL_16:  bits = 6'd16;
      DAL_24:  bits = 6'd24;
      default: bits = 6'd32;
    endcase
    return bits;
  endfunction

endpackage

// File: rtl/i2s_rx_sync.sv
// Brings the asynchronous SCK/WS/SD lines into the clk_i domain and produces a
// registered one-cycle SCK-rise pulse together with the WS/SD values sampled at that rise.
module i2s_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sck_i,
  input  logic ws_i,
  input  logic sd_i,
  output logic sck_rise_o,
  output logic ws_o,
  output logic sd_o
);

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] ws_sync_q, ws_sync_d;
  logic [SYNC_STAGES-1:0] sd_sync_q, sd_sync_d;
  logic sck_dly_q, sck_dly_d;
  logic rise_q, rise_d;
  logic ws_q, ws_d;
  logic sd_q, sd_d;
  logic sck_s, ws_s, sd_s, rise;

  assign sck_s = sck_sync_q[SYNC_STAGES-1];
  assign ws_s  = ws_sync_q[SYNC_STAGES-1];
  assign sd_s  = sd_sync_q[SYNC_STAGES-1];
  assign rise  = sck_s & ~sck_dly_q;

  always_comb begin
    sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], sck_i};
    ws_sync_d  = {ws_sync_q[SYNC_STAGES-2:0], ws_i};
    sd_sync_d  = {sd_sync_q[SYNC_STAGES-2:0], sd_i};
    sck_dly_d  = sck_s;
    rise_d     = rise;
    ws_d       = rise ? ws_s : ws_q;
    sd_d       = rise ? sd_s : sd_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_sync_q <= '0;
      ws_sync_q  <= '0;
      sd_sync_q  <= '0;
      sck_dly_q  <= 1'b0;
      rise_q     <= 1'b0;
      ws_q       <= 1'b0;
      sd_q       <= 1'b0;
    end else begin
      sck_sync_q <= sck_sync_d;
      ws_sync_q  <= ws_sync_d;
      sd_sync_q  <= sd_sync_d;
      sck_dly_q  <= sck_dly_d;
      rise_q     <= rise_d;
      ws_q       <= ws_d;
      sd_q       <= sd_d;
    end
  end

  assign sck_rise_o = rise_q;
  assign ws_o       = ws_q;
  assign sd_o       = sd_q;

endmodule

// File: rtl/i2s_rx_core.sv
// Slave-mode I2S receiver: deserialises each WS slot, extracts the audio word
// for the configured format/length and offers it on a single-entry valid/ready output.
module i2s_rx_core
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [1:0]            wm_i,
  input  logic [1:0]            fmt_i,
  input  logic [1:0]            chm_i,
  input  logic                  chl_i,
  input  logic [1:0]            dal_i,
  input  logic                  lsb_i,
  input  logic                  clr_i,
  output logic                  busy_o,
  output logic                  ovf_o,
  output logic                  frm_err_o,
  output logic                  rx_valid_o,
  input  logic                  rx_ready_i,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_chn_o,
  input  logic                  i2s_sck_i,
  input  logic                  i2s_ws_i,
  input  logic                  i2s_sd_i
);

  logic sck_rise, ws_smp, sd_smp;
  rx_state_e state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d, rx_data_q, rx_data_d;
  logic ws_dly_q, ws_dly_d, fws_prev_q, fws_prev_d;
  logic rx_valid_q, rx_valid_d, rx_chn_q, rx_chn_d;
  logic ovf_q, ovf_d, frm_err_q, frm_err_d;
  logic active, fws, boundary, keep_chn, emit;
  logic [5:0] dal, chl;
  logic [DATA_WIDTH-1:0] mask, masked, rev_all, word;

  i2s_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .sck_i      (i2s_sck_i),
    .ws_i       (i2s_ws_i),
    .sd_i       (i2s_sd_i),
    .sck_rise_o (sck_rise),
    .ws_o       (ws_smp),
    .sd_o       (sd_smp)
  );

  assign active   = en_i && (wm_i == WM_RECV);
  assign dal      = dal_bits(dal_i);
  assign chl      = (chl_i == CHL_32) ? 6'd32 : 6'd16;
  // I2S frames lag WS by one bit, so the delayed WS sample marks the slot.
  assign fws      = (fmt_i == FMT_I2S) ? ws_dly_q : ws_smp;
  assign boundary = sck_rise && (fws != fws_prev_q);
  assign keep_chn = !((chm_i == CHM_LEFT && fws_prev_q) || (chm_i == CHM_RIGHT && !fws_prev_q));

  always_comb begin
    mask    = (DATA_WIDTH'(1) << dal) - DATA_WIDTH'(1);
    masked  = shreg_q & mask;
    rev_all = '0;
    for (int i = 0; i < DATA_WIDTH; i++) rev_all[i] = masked[DATA_WIDTH-1-i];
    word    = lsb_i ? (rev_all >> (6'd32 - dal)) : masked;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    ws_dly_d   = ws_dly_q;
    fws_prev_d = fws_prev_q;
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    rx_chn_d   = rx_chn_q;
    ovf_d      = ovf_q;
    frm_err_d  = frm_err_q;
    emit       = 1'b0;

    if (sck_rise) begin
      ws_dly_d   = ws_smp;
      fws_prev_d = fws;
    end
    if (clr_i) begin
      ovf_d     = 1'b0;
      frm_err_d = 1'b0;
    end
    if (rx_valid_q && rx_ready_i) rx_valid_d = 1'b0;

    if (!active) begin
      state_d    = IDLE;
      cnt_d      = '0;
      shreg_d    = '0;
      rx_valid_d = 1'b0;
      rx_data_d  = '0;
      rx_chn_d   = 1'b0;
      ovf_d      = 1'b0;
      frm_err_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: state_d = SYNC;
        SYNC: begin
          if (boundary) begin
            state_d = RECV;
            cnt_d   = 6'd1;
            shreg_d = {{(DATA_WIDTH-1){1'b0}}, sd_smp};
          end
        end
        RECV: begin
          if (boundary) begin
            if (cnt_q != chl) frm_err_d = 1'b1;
            if (cnt_q < dal) frm_err_d = 1'b1;
            else emit = keep_chn;
            cnt_d   = 6'd1;
            shreg_d = {{(DATA_WIDTH-1){1'b0}}, sd_smp};
          end else if (sck_rise) begin
            if (cnt_q != 6'd63) cnt_d = cnt_q + 6'd1;
            if (fmt_i == FMT_LSB || cnt_q < dal) shreg_d = {shreg_q[DATA_WIDTH-2:0], sd_smp};
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // A pending, unaccepted word wins over a new one; the new word is lost.
    if (emit) begin
      if (rx_valid_q && !rx_ready_i) begin
        ovf_d = 1'b1;
      end else begin
        rx_valid_d = 1'b1;
        rx_data_d  = word;
        rx_chn_d   = fws_prev_q;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      ws_dly_q   <= 1'b0;
      fws_prev_q <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_chn_q   <= 1'b0;
      ovf_q      <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      ws_dly_q   <= ws_dly_d;
      fws_prev_q <= fws_prev_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      rx_chn_q   <= rx_chn_d;
      ovf_q      <= ovf_d;
      frm_err_q  <= frm_err_d;
    end
  end

  assign busy_o     = (state_q == RECV) && (cnt_q != 6'd0);
  assign ovf_o      = ovf_q;
  assign frm_err_o  = frm_err_q;
  assign rx_valid_o = rx_valid_q;
  assign rx_data_o  = rx_data_q;
  assign rx_chn_o   = rx_chn_q;

endmodule
